// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, latches fetched words, decodes rs/rt/branch.
// Optional performance counters (stall_cycles, flush_count) are enabled by defining IFID_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_pc_plus4,
    output logic        IFID_valid,
    output logic [4:0]  IFID_register_rs,
    output logic [4:0]  IFID_register_rt,
    output logic        IFID_branch
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic [5:0]  opcode;

    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr       = pc;

    // Priority: rst > stall > redirect > normal fetch; a stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC_ALIGNED;
            IFID_instr    <= NOP_WORD;
            IFID_pc_plus4 <= '0;
            IFID_valid    <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                pc            <= redirect_target;
                IFID_instr    <= NOP_WORD;
                IFID_pc_plus4 <= '0;
                IFID_valid    <= 1'b0;
            end else begin
                pc            <= pc_plus4;
                IFID_instr    <= imem_rdata;
                IFID_pc_plus4 <= pc_plus4;
                IFID_valid    <= 1'b1;
            end
        end
    end

    assign opcode           = IFID_instr[31:26];
    assign IFID_register_rs = IFID_instr[25:21];
    assign IFID_register_rt = IFID_instr[20:16];
    // Flushed slots never report a branch, so they cannot trigger a hazard stall.
    assign IFID_branch      = IFID_valid && ((opcode == 6'b000100) || (opcode == 6'b000101));

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (!stall && redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched word into IF/ID.
- Decodes the rs/rt/branch fields that the hazard detection logic consumes.
- Honours the hazard unit's stall (hold) and the ID-stage redirect (branch/jump taken), which flushes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  from hazard detection; hold PC and IF/ID
redirect  input  1  from ID stage; branch/jump taken this cycle
redirect_pc  input  32  target PC for redirect
imem_addr  output  32  instruction memory address (= current PC)
imem_rdata  input  32  instruction word, combinational read of imem_addr
IFID_instr  output  32  latched instruction
IFID_pc_plus4  output  32  latched PC+4 of that instruction
IFID_valid  output  1  IF/ID holds a real (non-flushed) instruction
IFID_register_rs  output  5  IFID_instr[25:21]
IFID_register_rt  output  5  IFID_instr[20:16]
IFID_branch  output  1  IFID_valid and opcode is 6'b000100 (beq) or 6'b000101 (bne)
stall_cycles  output  32  only with IFID_PERF_CNT_EN
flush_count  output  32  only with IFID_PERF_CNT_EN

Behaviour:
- Single clock domain. Priority per edge: rst > stall > redirect > normal fetch.
- Reset values:
  - pc = RESET_PC, with bits [1:0] forced to 00.
  - IFID_instr = NOP_WORD, IFID_pc_plus4 = 0, IFID_valid = 0.
  - Perf counters = 0.
- imem_addr = pc, combinational. Fetch latency: one cycle from address to IFID_instr.
- Normal fetch (no stall, no redirect):
  - pc <= pc + 4.
  - IFID_instr <= imem_rdata.
  - IFID_pc_plus4 <= pc + 4.
  - IFID_valid <= 1.
- Stall = 1: pc and all IF/ID registers hold. redirect is ignored that cycle. The ID stage must keep redirect asserted until stall drops, because the branch in ID is itself stalled.
- Redirect = 1 with stall = 0:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IFID_instr <= NOP_WORD, IFID_pc_plus4 <= 0, IFID_valid <= 0.
  - The wrong-path word on imem_rdata is discarded.
  - No branch delay slot.
- Back-to-back redirects: each one flushes; IFID_valid stays 0 until the first non-redirect fetch.
- Arithmetic: pc + 4 is 32-bit modulo. 0xFFFF_FFFC + 4 = 0x0000_0000, with no error flag.
- Decoded outputs are combinational from the IF/ID registers.
  - IFID_branch = 0 whenever IFID_valid = 0, so a flushed NOP never causes a hazard stall.
  - rs/rt are passed through unmasked. A NOP yields 0, and the hazard logic ignores register 0.
- rst asserted mid-stall or mid-redirect: reset values are taken on that edge. Both inputs are ignored.
- Out of scope: imem_rdata X-checking and misaligned-fetch exceptions.

Optional Feature:
Macro IFID_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every non-reset edge with stall = 1.
  - flush_count increments on every non-reset edge where a redirect is taken (redirect = 1, stall = 0).
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: both ports and their registers are absent. All other behaviour is identical.

Test Plan:
1. rst high 2 cycles, then low → imem_addr 0x0, IFID_instr 0x0, IFID_valid 0, IFID_branch 0; 1 cycle later imem_addr 0x4.
2. imem returns 0x8C010000, 0x00221820, 0x10220003 at addresses 0x0/0x4/0x8 → IFID_instr follows one cycle later, IFID_pc_plus4 = 4, 8, 0xC; on the third, IFID_branch = 1, rs = 1, rt = 2.
3. stall high 2 cycles while IFID_instr = 0x00221820 at pc 0x8 → IFID_instr, IFID_pc_plus4 and imem_addr unchanged for both cycles; fetch resumes at 0x8 after release; stall_cycles = 2 if enabled.
4. redirect = 1, redirect_pc = 0x0000_0043, stall = 0 → next edge: imem_addr 0x40, IFID_instr 0x0, IFID_valid 0, IFID_branch 0; flush_count = 1 if enabled.
5. stall = 1 and redirect = 1 same cycle → nothing changes; stall drops with redirect still high → redirect taken on that edge.
6. redirect to 0xFFFF_FFFC, then one normal fetch → pc wraps to 0x0, IFID_pc_plus4 = 0x0, IFID_valid = 1.
